fetch: RTL and testbench

- Instruction-fetch stage sitting directly upstream of decode.
- Owns the architectural fetch PC and drives a synchronous instruction BRAM (1-cycle read latency, output held while enable is low).
- Delivers an aligned (pc, inst, valid) triple to decode.
- Takes branch/jump redirects, external hazard stalls, multi-cycle wait counts and stop from decode and the pipeline.

---
 rtl/fetch.sv | 135 +++++++++++++
 tb/tb_fetch.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the fetch PC, drives a 1-cycle-latency
// instruction BRAM and hands an aligned (pc, inst, valid) triple to decode.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   RUN   | fetching; advances, holds or redirects every cycle
//   HALT  | stop instruction retired; BRAM idle, all registers frozen
//
// The PC register (pc_q) always names the word sitting on imem_rdata, so
// inst is a plain passthrough of the BRAM output. Holding works by dropping
// imem_en, which keeps the BRAM output (and therefore inst) stable.
//
// A wait_load that requests extra cycles holds the instruction in the load
// cycle itself; the counter then covers the remaining wait_time-2 cycles
// (wcnt counts down from wait_time-1 and holds while it is above 1).
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned IMEM_AW  = 14
) (
  input  logic               clk,
  input  logic               rst,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic               imem_en,
  input  logic [31:0]        imem_rdata,
  input  logic               stall,
  input  logic               wait_load,
  input  logic [4:0]         wait_time,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  input  logic               stop,
  output logic [31:0]        pc,
  output logic [31:0]        inst,
  output logic               valid,
  output logic               halted
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fpc_q, fpc_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [4:0]  wcnt_q, wcnt_d;

  logic        run;
  logic        wait_req;
  logic        hold;
  logic        stop_take;
  logic        redir_take;
  logic [31:0] redir_al;
  logic [31:0] fetch_addr;

  // Address bits beyond the BRAM depth alias silently; low bits are word offset.
  logic        unused_addr_bits;
  assign unused_addr_bits = ^{fetch_addr[31:IMEM_AW+2], fetch_addr[1:0],
                              redirect_pc[1:0]};

  assign inst   = imem_rdata;
  assign pc     = pc_q;
  assign valid  = valid_q;
  assign halted = (state_q == S_HALT);

  // Per-cycle decisions: stop beats redirect, redirect beats hold.
  always_comb begin
    run        = (state_q == S_RUN);
    wait_req   = wait_load & (wait_time > 5'd1);
    hold       = stall | (wcnt_q > 5'd1) | wait_req;
    stop_take  = run & stop & valid_q;
    redir_take = run & redirect & ~stop_take;
    redir_al   = {redirect_pc[31:2], 2'b00};
    fetch_addr = redir_take ? redir_al : fpc_q;
    imem_en    = run & (~hold | redir_take);
    imem_addr  = fetch_addr[IMEM_AW+1:2];
  end

  // Next-state logic for the RUN/HALT machine and the fetch registers.
  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      S_RUN: begin
        if (stop_take) begin
          state_d = S_HALT;
          valid_d = 1'b0;
        end else if (redir_take) begin
          fpc_d   = redir_al + 32'd4;
          pc_d    = redir_al;
          valid_d = 1'b1;
          wcnt_d  = 5'd0;
        end else begin
          if (!hold) begin
            fpc_d   = fpc_q + 32'd4;
            pc_d    = fpc_q;
            valid_d = 1'b1;
          end
          if (wait_req) begin
            wcnt_d = wait_time - 5'd1;
          end else if (wcnt_q != 5'd0) begin
            wcnt_d = wcnt_q - 5'd1;
          end
        end
      end
      S_HALT: begin
        // frozen until reset
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  // State register with synchronous reset; reset aborts any hold or halt.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      fpc_q   <= RESET_PC;
      pc_q    <= 32'd0;
      valid_q <= 1'b0;
      wcnt_q  <= 5'd0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      wcnt_q  <= wcnt_d;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed vector table, hand-written wait/reset sequences,
// then randomized traffic against a cycle-level behavioural model.
module tb_fetch;

  logic        clk;
  logic        rst;
  logic [13:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        wait_load;
  logic [4:0]  wait_time;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stop;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        valid;
  logic        halted;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [0:16383];

  fetch #(.RESET_PC(32'h0), .IMEM_AW(14)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_en     (imem_en),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .wait_load   (wait_load),
    .wait_time   (wait_time),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stop        (stop),
    .pc          (pc),
    .inst        (inst),
    .valid       (valid),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous BRAM: 1-cycle read, output held while enable is low.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem[imem_addr];
  end

  typedef struct {
    logic        rst, stall, wl;
    logic [4:0]  wt;
    logic        rd;
    logic [31:0] rpc;
    logic        st;
    logic        chk, ev;
    logic [31:0] epc, einst;
    logic        een;
    logic [13:0] eaddr;
    logic        eh;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic r, s, wl, input int wt, input logic rd,
                             input logic [31:0] rp, input logic st, input logic chk, ev,
                             input logic [31:0] epc, einst, input logic een,
                             input int ea, input logic eh);
    vec_t x;
    x.rst = r; x.stall = s; x.wl = wl; x.wt = 5'(wt); x.rd = rd; x.rpc = rp; x.st = st;
    x.chk = chk; x.ev = ev; x.epc = epc; x.einst = einst; x.een = een;
    x.eaddr = 14'(ea); x.eh = eh;
    return x;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic ev, input logic [31:0] epc,
                           input logic [31:0] einst, input logic een,
                           input logic [13:0] eaddr, input logic eh);
    cmp({tag, ".valid"},   32'(valid),   32'(ev));
    cmp({tag, ".halted"},  32'(halted),  32'(eh));
    cmp({tag, ".imem_en"}, 32'(imem_en), 32'(een));
    if (ev) begin
      cmp({tag, ".pc"},   pc,   epc);
      cmp({tag, ".inst"}, inst, einst);
    end
    if (een) cmp({tag, ".imem_addr"}, 32'(imem_addr), 32'(eaddr));
  endtask

  task automatic drive(input logic r, s, wl, input logic [4:0] wt, input logic rd,
                       input logic [31:0] rp, input logic st);
    rst = r; stall = s; wait_load = wl; wait_time = wt;
    redirect = rd; redirect_pc = rp; stop = st;
  endtask

  task automatic step(input string tag, input logic r, s, wl, input logic [4:0] wt,
                      input logic rd, input logic [31:0] rp, input logic st,
                      input logic chk, ev, input logic [31:0] epc, einst,
                      input logic een, input logic [13:0] eaddr, input logic eh);
    @(negedge clk);
    drive(r, s, wl, wt, rd, rp, st);
    #1;
    if (chk) check_out(tag, ev, epc, einst, een, eaddr, eh);
  endtask

  // Behavioural model: m_left counts future cycles still owed to a wait.
  logic [31:0] m_fpc, m_pc;
  logic        m_valid, m_halt, m_known;
  int          m_left;
  int          halt_cnt;

  initial begin
    for (int k = 0; k < 16384; k++) mem[k] = 32'(k);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0);

    // reset, free run, 3-cycle stall at pc=8
    vecs.push_back(v(1,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0, 1,0,0,0,1,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0, 1,1,0,0,1,1,0));
    vecs.push_back(v(0,0,0,0,0,0,0, 1,1,4,1,1,2,0));
    vecs.push_back(v(0,1,0,0,0,0,0, 1,1,8,2,0,0,0));
    vecs.push_back(v(0,1,0,0,0,0,0, 1,1,8,2,0,0,0));
    vecs.push_back(v(0,1,0,0,0,0,0, 1,1,8,2,0,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0, 1,1,8,2,1,3,0));
    vecs.push_back(v(0,0,0,0,0,0,0, 1,1,12,3,1,4,0));
    // redirect to 0x100 at pc=4, zero bubble
    vecs.push_back(v(1,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0, 1,0,0,0,1,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0, 1,1,0,0,1,1,0));
    vecs.push_back(v(0,0,0,0,1,32'h100,0, 1,1,4,1,1,'h40,0));
    vecs.push_back(v(0,0,0,0,0,0,0, 1,1,32'h100,32'h40,1,'h41,0));
    vecs.push_back(v(0,0,0,0,0,0,0, 1,1,32'h104,32'h41,1,'h42,0));
    // wait_time=5 at pc=16, then stop at pc=20, redirect while halted
    vecs.push_back(v(1,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0, 1,0,0,0,1,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0, 1,1,0,0,1,1,0));
    vecs.push_back(v(0,0,0,0,0,0,0, 1,1,4,1,1,2,0));
    vecs.push_back(v(0,0,0,0,0,0,0, 1,1,8,2,1,3,0));
    vecs.push_back(v(0,0,0,0,0,0,0, 1,1,12,3,1,4,0));
    vecs.push_back(v(0,0,1,5,0,0,0, 1,1,16,4,0,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0, 1,1,16,4,0,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0, 1,1,16,4,0,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0, 1,1,16,4,0,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0, 1,1,16,4,1,5,0));
    vecs.push_back(v(0,0,0,0,0,0,1, 1,1,20,5,1,6,0));
    vecs.push_back(v(0,0,0,0,0,0,0, 1,0,0,0,0,0,1));
    vecs.push_back(v(0,0,0,0,1,32'h200,0, 1,0,0,0,0,0,1));
    vecs.push_back(v(0,0,0,0,0,0,0, 1,0,0,0,0,0,1));
    // reset out of halt, then stop together with redirect
    vecs.push_back(v(1,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0, 1,0,0,0,1,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0, 1,1,0,0,1,1,0));
    vecs.push_back(v(0,0,0,0,1,32'h300,1, 1,1,4,1,1,2,0));
    vecs.push_back(v(0,0,0,0,0,0,0, 1,0,0,0,0,0,1));
    vecs.push_back(v(0,0,0,0,0,0,0, 1,0,0,0,0,0,1));
    // unaligned redirect, PC wrap, address aliasing
    vecs.push_back(v(1,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0, 1,0,0,0,1,0,0));
    vecs.push_back(v(0,0,0,0,1,32'h203,0, 1,1,0,0,1,'h80,0));
    vecs.push_back(v(0,0,0,0,1,32'hFFFF_FFFC,0, 1,1,32'h200,32'h80,1,'h3FFF,0));
    vecs.push_back(v(0,0,0,0,0,0,0, 1,1,32'hFFFF_FFFC,32'h3FFF,1,0,0));
    vecs.push_back(v(0,0,0,0,1,32'h0001_0010,0, 1,1,0,0,1,4,0));
    vecs.push_back(v(0,0,0,0,0,0,0, 1,1,32'h0001_0010,4,1,5,0));

    foreach (vecs[i])
      step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].stall, vecs[i].wl, vecs[i].wt,
           vecs[i].rd, vecs[i].rpc, vecs[i].st, vecs[i].chk, vecs[i].ev, vecs[i].epc,
           vecs[i].einst, vecs[i].een, vecs[i].eaddr, vecs[i].eh);

    // wait reload: shrink (5 then 2), then test-plan reload (5 then 3)
    step("rl_rst", 1,0,0,0,0,0,0, 0,0,0,0,0,0,0);
    step("rl0",  0,0,0,0,0,0,0, 1,0,0,0,1,0,0);
    step("rl1",  0,0,0,0,0,0,0, 1,1,0,0,1,1,0);
    step("rl2",  0,0,1,5,0,0,0, 1,1,4,1,0,0,0);
    step("rl3",  0,0,1,2,0,0,0, 1,1,4,1,0,0,0);
    step("rl4",  0,0,0,0,0,0,0, 1,1,4,1,1,2,0);
    step("rl5",  0,0,1,5,0,0,0, 1,1,8,2,0,0,0);
    step("rl6",  0,0,0,0,0,0,0, 1,1,8,2,0,0,0);
    step("rl7",  0,0,1,3,0,0,0, 1,1,8,2,0,0,0);
    step("rl8",  0,0,0,0,0,0,0, 1,1,8,2,0,0,0);
    step("rl9",  0,0,0,0,0,0,0, 1,1,8,2,1,3,0);
    step("rl10", 0,0,0,0,0,0,0, 1,1,12,3,1,4,0);

    // reset while stalled with wcnt=10
    step("rs_rst", 1,0,0,0,0,0,0, 0,0,0,0,0,0,0);
    step("rs0", 0,0,0,0,0,0,0,  1,0,0,0,1,0,0);
    step("rs1", 0,0,1,11,0,0,0, 1,1,0,0,0,0,0);
    step("rs2", 1,1,0,0,0,0,0,  1,1,0,0,0,0,0);
    step("rs3", 0,0,0,0,0,0,0,  1,0,0,0,1,0,0);
    step("rs4", 0,0,0,0,0,0,0,  1,1,0,0,1,1,0);
    step("rs5", 0,0,0,0,0,0,0,  1,1,4,1,1,2,0);

    // randomized traffic against the model
    m_known = 1'b0; halt_cnt = 0;
    m_fpc = 0; m_pc = 0; m_valid = 0; m_halt = 0; m_left = 0;
    for (int n = 0; n < 4000; n++) begin
      logic r, s, wl, rd, st;
      logic [4:0]  wt;
      logic [31:0] rp;
      logic stop_t, rd_t, wreq, held, e_en;
      logic [31:0] al, e_addr;
      @(negedge clk);
      r  = (n == 0) || ($urandom_range(0, 299) == 0) || (m_halt && halt_cnt > 4);
      s  = ($urandom_range(0, 6) == 0);
      wl = ($urandom_range(0, 9) == 0);
      wt = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
      rd = ($urandom_range(0, 11) == 0);
      rp = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      st = ($urandom_range(0, 149) == 0);
      drive(r, s, wl, wt, rd, rp, st);
      #1;
      al     = {rp[31:2], 2'b00};
      stop_t = st & m_valid;
      rd_t   = rd & ~stop_t;
      wreq   = wl & (wt > 5'd1);
      held   = s | (m_left > 0) | wreq;
      e_en   = m_halt ? 1'b0 : (~held | rd_t);
      e_addr = rd_t ? al : m_fpc;
      if (m_known) begin
        cmp("rnd.valid",   32'(valid),   32'(m_valid));
        cmp("rnd.halted",  32'(halted),  32'(m_halt));
        cmp("rnd.pc",      pc,           m_pc);
        cmp("rnd.imem_en", 32'(imem_en), 32'(e_en));
        if (e_en)    cmp("rnd.imem_addr", 32'(imem_addr), 32'(e_addr[15:2]));
        if (m_valid) cmp("rnd.inst", inst, mem[m_pc[15:2]]);
      end
      if (r) begin
        m_known = 1'b1; m_fpc = 32'h0; m_pc = 0; m_valid = 0; m_halt = 0; m_left = 0;
      end else if (!m_halt) begin
        if (stop_t) begin
          m_halt = 1'b1; m_valid = 1'b0;
        end else if (rd_t) begin
          m_pc = al; m_fpc = al + 32'd4; m_valid = 1'b1; m_left = 0;
        end else begin
          if (!held) begin
            m_pc = m_fpc; m_fpc = m_fpc + 32'd4; m_valid = 1'b1;
          end
          if (wreq) m_left = int'(wt) - 2;
          else if (m_left > 0) m_left = m_left - 1;
        end
      end
      halt_cnt = m_halt ? halt_cnt + 1 : 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
